rtc_timer_param: RTL

RTC_TIMER_PARAM -- requirements
Module: rtc_timer_param

---
 rtl/rtc_timer_param.sv | 134 +++++++++++++
 1 files changed

// File: rtl/rtc_timer_param.sv
// Parameterised RTC time-of-day counter. A fractional-ns accumulator advances
// by a programmable period each cycle and wraps at a programmable modulo,
// incrementing the seconds counter on each wrap. A timed adjustment adds a
// signed offset to the period for a fixed number of cycles.
module rtc_timer_param #(
  parameter int unsigned SEC_W  = 48,
  parameter int unsigned NS_W   = 30,
  parameter int unsigned NSF_W  = 8,
  parameter int unsigned PER_W  = 8,
  parameter int unsigned PERF_W = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    time_ld,
  input  logic [NS_W+NSF_W-1:0]   time_reg_ns_in,
  input  logic [SEC_W-1:0]        time_reg_sec_in,
  input  logic                    period_ld,
  input  logic [PER_W+PERF_W-1:0] period_in,
  input  logic [NS_W+NSF_W-1:0]   time_acc_modulo,
  input  logic                    adj_ld,
  input  logic [31:0]             adj_ld_data,
  input  logic [PER_W+PERF_W-1:0] period_adj,
  output logic [NS_W+NSF_W-1:0]   time_reg_ns,
  output logic [SEC_W-1:0]        time_reg_sec,
  output logic                    pps,
  output logic                    adj_busy,
  output logic                    adj_done
);

  localparam int unsigned TW    = NS_W + NSF_W;
  localparam int unsigned ACC_W = NS_W + PERF_W;
  localparam int unsigned PW    = PER_W + PERF_W;
  // Two guard bits: the signed sum of an unsigned period and a signed
  // adjustment cannot overflow at this width.
  localparam int unsigned SW    = PW + 2;
  localparam int unsigned PAD   = PERF_W - NSF_W;

  typedef enum logic [0:0] {StIdle, StAdj} state_e;

  state_e            state_q;
  logic [31:0]       count_q;
  logic [PW-1:0]     adj_q;
  logic              adj_done_q;

  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [SEC_W-1:0]  sec_q, sec_d;
  logic              pps_q, pps_d;
  logic [PW-1:0]     period_q, period_d;

  logic signed [SW-1:0] inc_s;
  logic [PW:0]          inc;
  logic [ACC_W:0]       nxt;
  logic [ACC_W:0]       mod_ext;

  assign adj_busy = (state_q == StAdj);

  // Per-cycle increment: period plus active adjustment, clamped at zero.
  always_comb begin
    inc_s = $signed({2'b00, period_q});
    if (adj_busy) begin
      inc_s = inc_s + $signed({{2{adj_q[PW-1]}}, adj_q});
    end
    inc = inc_s[SW-1] ? '0 : inc_s[PW:0];
  end

  // Accumulate, wrap at the modulo, and handle time loads.
  always_comb begin
    nxt      = {1'b0, acc_q} + (ACC_W+1)'(inc);
    mod_ext  = (ACC_W+1)'(time_acc_modulo) << PAD;
    acc_d    = nxt[ACC_W-1:0];
    sec_d    = sec_q;
    pps_d    = 1'b0;
    period_d = period_ld ? period_in : period_q;
    if (time_ld) begin
      // A load replaces this cycle's increment and never raises pps.
      acc_d = ACC_W'(time_reg_ns_in) << PAD;
      sec_d = time_reg_sec_in;
    end else if (nxt >= mod_ext) begin
      acc_d = ACC_W'(nxt - mod_ext);
      sec_d = sec_q + 1'b1;
      pps_d = 1'b1;
    end
  end

  // Time-of-day and period registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= '0;
      sec_q    <= '0;
      pps_q    <= 1'b0;
      period_q <= '0;
    end else begin
      acc_q    <= acc_d;
      sec_q    <= sec_d;
      pps_q    <= pps_d;
      period_q <= period_d;
    end
  end

  // Adjustment FSM: a valid load (re)starts a run; the last busy cycle
  // returns to idle and pulses adj_done. A restart aborts silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      count_q    <= '0;
      adj_q      <= '0;
      adj_done_q <= 1'b0;
    end else begin
      adj_done_q <= 1'b0;
      if (adj_ld && (adj_ld_data != 32'd0)) begin
        state_q <= StAdj;
        count_q <= adj_ld_data;
        adj_q   <= period_adj;
      end else begin
        unique case (state_q)
          StAdj: begin
            count_q <= count_q - 32'd1;
            if (count_q == 32'd1) begin
              state_q    <= StIdle;
              adj_done_q <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign time_reg_ns  = acc_q[ACC_W-1 -: TW];
  assign time_reg_sec = sec_q;
  assign pps          = pps_q;
  assign adj_done     = adj_done_q;

endmodule
